// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: ALU ops, forwarding selects,
// branch fun3 codes and result-source codes.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the pipeline; arithmetic wraps
// modulo 2^XLEN and shifts use the low five bits of srcB.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [2:0]      aluControl,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (aluControl)
            ALU_ADD: result = srcA + srcB;
            ALU_SUB: result = srcA - srcB;
            ALU_AND: result = srcA & srcB;
            ALU_OR:  result = srcA | srcB;
            ALU_XOR: result = srcA ^ srcB;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            ALU_SLL: result = srcA << srcB[4:0];
            ALU_SRL: result = srcA >> srcB[4:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch comparator and jump
// redirect, followed by the EX/MEM pipeline register.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            regWriteE,
    input  logic            memWriteE,
    input  logic            aluSrcE,
    input  logic            branchE,
    input  logic            jumpE,
    input  logic [1:0]      resultSrcE,
    input  logic [2:0]      aluControlE,
    input  logic [2:0]      fun3E,
    input  logic [XLEN-1:0] rd1E,
    input  logic [XLEN-1:0] rd2E,
    input  logic [XLEN-1:0] immE,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] pc_4E,
    input  logic [4:0]      rdE,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] resultW,
    output logic            pcSrcE,
    output logic [XLEN-1:0] pcTargetE,
    output logic            regWriteM,
    output logic            memWriteM,
    output logic [1:0]      resultSrcM,
    output logic [2:0]      fun3M,
    output logic [XLEN-1:0] aluResultM,
    output logic [XLEN-1:0] writeDataM,
    output logic [XLEN-1:0] pc_4M,
    output logic [4:0]      rdM
);

    logic [XLEN-1:0] w_srcAE;
    logic [XLEN-1:0] w_writeDataE;
    logic [XLEN-1:0] w_srcBE;
    logic [XLEN-1:0] w_aluResultE;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;

    logic            r_regWriteM;
    logic            r_memWriteM;
    logic [1:0]      r_resultSrcM;
    logic [2:0]      r_fun3M;
    logic [XLEN-1:0] r_aluResultM;
    logic [XLEN-1:0] r_writeDataM;
    logic [XLEN-1:0] r_pc_4M;
    logic [4:0]      r_rdM;

    // The reserved select code 11 falls back to the register-file value.
    always_comb begin
        w_srcAE = rd1E;
        case (forwardAE)
            FWD_WB:  w_srcAE = resultW;
            FWD_MEM: w_srcAE = r_aluResultM;
            default: w_srcAE = rd1E;
        endcase
    end

    always_comb begin
        w_writeDataE = rd2E;
        case (forwardBE)
            FWD_WB:  w_writeDataE = resultW;
            FWD_MEM: w_writeDataE = r_aluResultM;
            default: w_writeDataE = rd2E;
        endcase
    end

    assign w_srcBE = aluSrcE ? immE : w_writeDataE;

    alu #(.XLEN(XLEN)) u_alu (
        .srcA       (w_srcAE),
        .srcB       (w_srcBE),
        .aluControl (aluControlE),
        .result     (w_aluResultE)
    );

    // Comparator works on the register operands, never the immediate.
    assign w_eq  = (w_srcAE == w_writeDataE);
    assign w_lt  = ($signed(w_srcAE) < $signed(w_writeDataE));
    assign w_ltu = (w_srcAE < w_writeDataE);

    always_comb begin
        w_cond = 1'b0;
        case (fun3E)
            F3_BEQ:  w_cond = w_eq;
            F3_BNE:  w_cond = ~w_eq;
            F3_BLT:  w_cond = w_lt;
            F3_BGE:  w_cond = ~w_lt;
            F3_BLTU: w_cond = w_ltu;
            F3_BGEU: w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign pcSrcE    = (branchE & w_cond) | jumpE;
    assign pcTargetE = pcE + immE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_resultSrcM <= '0;
            r_fun3M      <= '0;
            r_aluResultM <= '0;
            r_writeDataM <= '0;
            r_pc_4M      <= '0;
            r_rdM        <= '0;
        end else begin
            r_regWriteM  <= regWriteE;
            r_memWriteM  <= memWriteE;
            r_resultSrcM <= resultSrcE;
            r_fun3M      <= fun3E;
            r_aluResultM <= w_aluResultE;
            r_writeDataM <= w_writeDataE;
            r_pc_4M      <= pc_4E;
            r_rdM        <= rdE;
        end
    end

    assign regWriteM  = r_regWriteM;
    assign memWriteM  = r_memWriteM;
    assign resultSrcM = r_resultSrcM;
    assign fun3M      = r_fun3M;
    assign aluResultM = r_aluResultM;
    assign writeDataM = r_writeDataM;
    assign pc_4M      = r_pc_4M;
    assign rdM        = r_rdM;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of single-cycle vectors plus
// hand-written sequences for reset, M-stage forwarding and jumps.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        regWriteE, memWriteE, aluSrcE, branchE, jumpE;
    logic [1:0]  resultSrcE;
    logic [2:0]  aluControlE, fun3E;
    logic [31:0] rd1E, rd2E, immE, pcE, pc_4E, resultW;
    logic [4:0]  rdE;
    logic [1:0]  forwardAE, forwardBE;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic        regWriteM, memWriteM;
    logic [1:0]  resultSrcM;
    logic [2:0]  fun3M;
    logic [31:0] aluResultM, writeDataM, pc_4M;
    logic [4:0]  rdM;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  aluCtl;
        logic        aluSrc;
        logic        branch;
        logic        jump;
        logic [2:0]  fun3;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] resW;
        logic        expPcSrc;
        logic [31:0] expAlu;
        logic [31:0] expWd;
    } vec_t;

    vec_t vecs[$];

    ex_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .regWriteE   (regWriteE),
        .memWriteE   (memWriteE),
        .aluSrcE     (aluSrcE),
        .branchE     (branchE),
        .jumpE       (jumpE),
        .resultSrcE  (resultSrcE),
        .aluControlE (aluControlE),
        .fun3E       (fun3E),
        .rd1E        (rd1E),
        .rd2E        (rd2E),
        .immE        (immE),
        .pcE         (pcE),
        .pc_4E       (pc_4E),
        .rdE         (rdE),
        .forwardAE   (forwardAE),
        .forwardBE   (forwardBE),
        .resultW     (resultW),
        .pcSrcE      (pcSrcE),
        .pcTargetE   (pcTargetE),
        .regWriteM   (regWriteM),
        .memWriteM   (memWriteM),
        .resultSrcM  (resultSrcM),
        .fun3M       (fun3M),
        .aluResultM  (aluResultM),
        .writeDataM  (writeDataM),
        .pc_4M       (pc_4M),
        .rdM         (rdM)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] aluCtl, input logic aluSrc,
                                input logic branch, input logic jump,
                                input logic [2:0] fun3, input logic [1:0] fwdA,
                                input logic [1:0] fwdB, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [31:0] resW,
                                input logic expPcSrc, input logic [31:0] expAlu,
                                input logic [31:0] expWd);
        vec_t v;
        v.aluCtl = aluCtl;  v.aluSrc = aluSrc;  v.branch = branch;  v.jump = jump;
        v.fun3 = fun3;      v.fwdA = fwdA;      v.fwdB = fwdB;
        v.rd1 = rd1;        v.rd2 = rd2;        v.imm = imm;        v.pc = pc;
        v.resW = resW;      v.expPcSrc = expPcSrc;
        v.expAlu = expAlu;  v.expWd = expWd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        regWriteE   = 1'b1;
        memWriteE   = 1'b0;
        resultSrcE  = 2'b00;
        aluControlE = v.aluCtl;
        aluSrcE     = v.aluSrc;
        branchE     = v.branch;
        jumpE       = v.jump;
        fun3E       = v.fun3;
        forwardAE   = v.fwdA;
        forwardBE   = v.fwdB;
        rd1E        = v.rd1;
        rd2E        = v.rd2;
        immE        = v.imm;
        pcE         = v.pc;
        pc_4E       = v.pc + 32'd4;
        resultW     = v.resW;
        rdE         = 5'(idx + 1);
    endtask

    task automatic checkMZero(input string tag);
        checkOutput({tag, "_regWriteM"},  {31'd0, regWriteM}, 32'd0);
        checkOutput({tag, "_memWriteM"},  {31'd0, memWriteM}, 32'd0);
        checkOutput({tag, "_resultSrcM"}, {30'd0, resultSrcM}, 32'd0);
        checkOutput({tag, "_fun3M"},      {29'd0, fun3M}, 32'd0);
        checkOutput({tag, "_aluResultM"}, aluResultM, 32'd0);
        checkOutput({tag, "_writeDataM"}, writeDataM, 32'd0);
        checkOutput({tag, "_pc_4M"},      pc_4M, 32'd0);
        checkOutput({tag, "_rdM"},        {27'd0, rdM}, 32'd0);
    endtask

    initial begin
        // Reset with nonzero inputs present.
        reset_n     = 1'b0;
        regWriteE   = 1'b1;  memWriteE = 1'b1;  aluSrcE = 1'b0;
        branchE     = 1'b0;  jumpE     = 1'b0;  resultSrcE = 2'b01;
        aluControlE = 3'b000; fun3E    = 3'b010;
        rd1E = 32'h0000_0007; rd2E = 32'hFFFF_FFFE; immE = 32'h0; pcE = 32'h40;
        pc_4E = 32'h44; rdE = 5'd5; forwardAE = 2'b00; forwardBE = 2'b00;
        resultW = 32'h0;
        repeat (2) @(posedge clk);
        #1 checkMZero("reset");

        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_regWriteM",  {31'd0, regWriteM}, 32'd1);
        checkOutput("rel_memWriteM",  {31'd0, memWriteM}, 32'd1);
        checkOutput("rel_resultSrcM", {30'd0, resultSrcM}, 32'd1);
        checkOutput("rel_fun3M",      {29'd0, fun3M}, 32'd2);
        checkOutput("rel_aluResultM", aluResultM, 32'h0000_0005);
        checkOutput("rel_writeDataM", writeDataM, 32'hFFFF_FFFE);
        checkOutput("rel_pc_4M",      pc_4M, 32'h44);
        checkOutput("rel_rdM",        {27'd0, rdM}, 32'd5);

        //            alu     src br  jmp fun3    fA     fB     rd1           rd2           imm    pc      resW          pcS  alu           wd
        vecs.push_back(mk(3'd0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'h5,        32'hFFFFFFFE));
        vecs.push_back(mk(3'd1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'h9,        32'hFFFFFFFE));
        vecs.push_back(mk(3'd2, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'h6,        32'hFFFFFFFE));
        vecs.push_back(mk(3'd3, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFE));
        vecs.push_back(mk(3'd4, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'hFFFFFFF9, 32'hFFFFFFFE));
        vecs.push_back(mk(3'd5, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,   32'h0,        0, 32'h0,        32'hFFFFFFFE));
        vecs.push_back(mk(3'd6, 1, 0, 0, 3'b000, 2'b00, 2'b00, 32'h7,        32'hFFFFFFFE, 32'h4, 32'h0,   32'h0,        0, 32'h70,       32'hFFFFFFFE));
        vecs.push_back(mk(3'd7, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h80000000, 32'h21,       32'h0, 32'h0,   32'h0,        0, 32'h40000000, 32'h21));
        vecs.push_back(mk(3'd5, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h0,   32'h0,        0, 32'h1,        32'h1));
        vecs.push_back(mk(3'd1, 0, 1, 0, 3'b000, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        1, 32'h0,        32'h5));
        vecs.push_back(mk(3'd1, 0, 1, 0, 3'b001, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        0, 32'h0,        32'h5));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b100, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'hC, 32'h100, 32'h0,        1, 32'h0,        32'h1));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b101, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'hC, 32'h100, 32'h0,        0, 32'h0,        32'h1));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b110, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'hC, 32'h100, 32'h0,        0, 32'h0,        32'h1));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b111, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'hC, 32'h100, 32'h0,        1, 32'h0,        32'h1));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b010, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        0, 32'hA,        32'h5));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b011, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        0, 32'hA,        32'h5));
        vecs.push_back(mk(3'd0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        0, 32'hA,        32'h5));
        vecs.push_back(mk(3'd0, 0, 1, 1, 3'b001, 2'b00, 2'b00, 32'h5,        32'h5,        32'h8, 32'h100, 32'h0,        1, 32'hA,        32'h5));
        vecs.push_back(mk(3'd0, 0, 0, 0, 3'b000, 2'b11, 2'b11, 32'h3,        32'h4,        32'h0, 32'h0,   32'h100,      0, 32'h7,        32'h4));
        vecs.push_back(mk(3'd0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 32'h1,        32'h5,        32'h0, 32'h0,   32'h20,       0, 32'h21,       32'h20));
        vecs.push_back(mk(3'd0, 1, 0, 0, 3'b000, 2'b00, 2'b01, 32'h2,        32'h9,        32'h3, 32'h0,   32'h55,       0, 32'h5,        32'h55));
        vecs.push_back(mk(3'd0, 0, 1, 0, 3'b100, 2'b01, 2'b00, 32'h0,        32'h0,        32'h0, 32'h0,   32'hFFFFFFF0, 1, 32'hFFFFFFF0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i], i);
            #1;
            checkOutput($sformatf("v%0d_pcSrcE", i), {31'd0, pcSrcE}, {31'd0, vecs[i].expPcSrc});
            checkOutput($sformatf("v%0d_pcTargetE", i), pcTargetE, vecs[i].pc + vecs[i].imm);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_aluResultM", i), aluResultM, vecs[i].expAlu);
            checkOutput($sformatf("v%0d_writeDataM", i), writeDataM, vecs[i].expWd);
            checkOutput($sformatf("v%0d_rdM", i), {27'd0, rdM}, 32'(i + 1));
            checkOutput($sformatf("v%0d_fun3M", i), {29'd0, fun3M}, {29'd0, vecs[i].fun3});
            checkOutput($sformatf("v%0d_pc_4M", i), pc_4M, vecs[i].pc + 32'd4);
        end

        // Forwarding from the M-stage ALU result.
        @(negedge clk);
        aluControlE = 3'd0; aluSrcE = 1'b0; branchE = 1'b0; jumpE = 1'b0;
        fun3E = 3'b000; forwardAE = 2'b00; forwardBE = 2'b00;
        rd1E = 32'h10; rd2E = 32'h0; resultW = 32'h0;
        @(posedge clk);
        #1 checkOutput("fwd_seed", aluResultM, 32'h10);
        @(negedge clk);
        forwardAE = 2'b10; rd1E = 32'hDEAD; rd2E = 32'h3;
        @(posedge clk);
        #1 checkOutput("fwdA_mem", aluResultM, 32'h13);
        @(negedge clk);
        forwardAE = 2'b00; forwardBE = 2'b10; rd1E = 32'h13; rd2E = 32'hBEEF;
        branchE = 1'b1; fun3E = 3'b000;
        #1 checkOutput("fwdB_mem_beq", {31'd0, pcSrcE}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("fwdB_mem_alu", aluResultM, 32'h26);
        checkOutput("fwdB_mem_wd",  writeDataM, 32'h13);

        // Jump with PC+4 writeback.
        @(negedge clk);
        branchE = 1'b0; jumpE = 1'b1; forwardBE = 2'b00; resultSrcE = 2'b10;
        pcE = 32'h200; immE = 32'h40; pc_4E = 32'h204; rdE = 5'd1;
        #1;
        checkOutput("jal_pcSrcE", {31'd0, pcSrcE}, 32'd1);
        checkOutput("jal_pcTargetE", pcTargetE, 32'h240);
        @(posedge clk);
        #1;
        checkOutput("jal_pc_4M", pc_4M, 32'h204);
        checkOutput("jal_resultSrcM", {30'd0, resultSrcM}, 32'd2);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkMZero("async");
        checkOutput("async_pcTargetE", pcTargetE, 32'h240);
        checkOutput("async_pcSrcE", {31'd0, pcSrcE}, 32'd1);
        @(posedge clk);
        #1 checkOutput("async_hold_pc_4M", pc_4M, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("async_release_pc_4M", pc_4M, 32'h204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-V pipeline. It consumes the ID/EX pipeline register outputs and resolves operand forwarding. It computes the ALU result, branch condition and branch/jump target, and registers everything the memory stage needs into an internal EX/MEM pipeline register. Branch/jump redirect (`pcSrcE`, `pcTargetE`) is combinational back to fetch; all M-stage outputs are registered.

## Interface
- `XLEN`, 32: datapath width.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `regWriteE, memWriteE, aluSrcE, branchE, jumpE` input 1 each: E-stage controls from ID/EX.
- `resultSrcE` input 2: 00 ALU, 01 memory, 10 PC+4.
- `aluControlE` input 3: ALU op (encoding under Operation).
- `fun3E` input 3: branch type; forwarded as load/store size to M.
- `rd1E, rd2E, immE, pcE, pc_4E` input XLEN: operands, immediate, PC, PC+4.
- `rdE` input 5: destination register.
- `forwardAE, forwardBE` input 2: from hazard unit; 00 register file, 01 `resultW`, 10 `aluResultM`, 11 reserved (treated as 00).
- `resultW` input XLEN: writeback result.
- `pcSrcE` output 1: take branch/jump (combinational).
- `pcTargetE` output XLEN: `pcE + immE` (combinational).
- `regWriteM, memWriteM` output 1: registered controls.
- `resultSrcM` output 2: registered.
- `fun3M` output 3: registered.
- `aluResultM, writeDataM, pc_4M` output XLEN: registered.
- `rdM` output 5: registered.

## Operation
- Source A (`srcAE`) is selected by `forwardAE`.
- `writeDataE` is the forwarded B operand, selected by `forwardBE`.
- `srcBE` = `aluSrcE ? immE : writeDataE`.
- ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 SRL.
- Shifts use `srcBE[4:0]`.
- All arithmetic is modulo 2^XLEN; overflow is ignored.
- Branch condition comes from a dedicated comparator on `srcAE`/`writeDataE`, independent of `aluControlE`:
  - `fun3E` 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 give false.
- `pcSrcE` = `(branchE & cond) | jumpE`.
- `pcTargetE` = `pcE + immE`. JALR target is out of scope (a JAL-only jump path).
- EX/MEM register: on every rising edge, captures `regWriteE, memWriteE, resultSrcE, fun3E, aluResultE, writeDataE, pc_4E, rdE` into the M outputs.
- There is no stall or flush input. A flushed E bubble arrives as all-zero controls and propagates as a harmless bubble.
- `aluResultM` is fed back internally as forwarding source 10, so the register output is the forwarding value.

## Timing
- Combinational path: ID/EX outputs → forwarding mux → ALU/comparator → `pcSrcE`/`pcTargetE`, within one cycle.
- Latency from E inputs to M outputs is 1 cycle.
- Reset: while `reset_n`=0, all M outputs are 0 asynchronously; they stay 0 until the first rising edge after deassertion.
- Reset mid-operation discards the in-flight M contents.
- `pcSrcE`/`pcTargetE` follow their inputs during reset. The upstream ID/EX register zeroes them in practice.
- Simultaneous `branchE` and `jumpE`: `pcSrcE`=1, target unchanged.
- `rdE`=0 with `regWriteE`=1 is passed through unchanged. Dropping x0 writes is the register file's job.

## Structure
- Shared package `riscv_pkg`:
  - ALU op localparams (`ALU_ADD` … `ALU_SRL`).
  - Forward select codes (`FWD_RF`, `FWD_WB`, `FWD_MEM`).
  - Branch fun3 codes.
  - Result-source codes.
- Sub-module `alu` (`srcA`, `srcB`, `aluControl` → `result`), combinational and reused elsewhere.
- Forwarding muxes, comparator and EX/MEM register live in `ex_stage`.

## Test plan
- Reset: hold `reset_n`=0 with nonzero inputs, clock → all M outputs 0. Release, one edge → M outputs equal the E inputs.
- ALU ops: `rd1E`=0x0000_0007, `rd2E`=0xFFFF_FFFE, `aluSrcE`=0, forwards 00. One edge each gives:
  - ADD → `aluResultM`=0x0000_0005
  - SUB → 0x0000_0009
  - SLT → 0
  - SLL with `immE`=4, `aluSrcE`=1 → 0x0000_0070
- Forwarding:
  - `forwardAE`=10 with previous `aluResultM`=0x10, `rd2E`=0x3, ADD → next `aluResultM`=0x13.
  - `forwardBE`=01, `resultW`=0x20 → `writeDataM`=0x20.
- Branch:
  - `branchE`=1, `fun3E`=000, `rd1E`=`rd2E`=5 → `pcSrcE`=1, and `pcTargetE`=0x108 for `pcE`=0x100, `immE`=8.
  - `fun3E`=100 with `rd1E`=0xFFFF_FFFF, `rd2E`=1 → `pcSrcE`=1.
  - `fun3E`=110 with the same operands → `pcSrcE`=0.
- Jump: `jumpE`=1, `resultSrcE`=10, `pc_4E`=0x204 → `pcSrcE`=1, and next cycle `pc_4M`=0x204, `resultSrcM`=10.
- Async reset mid-stream: assert `reset_n`=0 between clock edges → M outputs drop to 0 before the next edge.
